decode_buffer: RTL and testbench

Parametrised instruction queue between fetch and decode stages, decoupling fetch from decode stalls (CSR write, divide, downstream hazards) with a DEPTH-entry FIFO instead of a single pipeline register. Carries each fetched instruction with its PC, fetch-side exception status, and precomputed next PC (2- or 4-byte step for compressed or full-length instructions). Flushed on redirect (jump, exception, mret, execute clear) so decode never sees wrong-path instructions.

---
 rtl/decode_buffer_pkg.sv | 45 ++++
 rtl/decode_buffer_if.sv | 39 +++
 rtl/decode_buffer.sv | 91 +++++++++
 tb/tb_decode_buffer.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_buffer_pkg.sv
// rtl/decode_buffer_pkg.sv - shared types, constants and next-PC helper for the decode buffer
package decode_buffer_pkg;

  localparam int DB_XLEN   = 32;
  localparam int DB_DEPTH  = 4;
  localparam int DB_CWIDTH = 4;
  localparam int DB_CNTW   = $clog2(DB_DEPTH + 1);

  // Low two instruction bits of 2'b11 mark a full-length (4-byte) instruction
  localparam logic [1:0] ILEN_FULL = 2'b11;

  typedef struct packed {
    logic [DB_XLEN-1:0]   pc;
    logic [DB_XLEN-1:0]   npc;
    logic [31:0]          instr;
    logic                 exception;
    logic [DB_CWIDTH-1:0] ecause;
    logic [DB_XLEN-1:0]   etval;
  } decode_buffer_entry_type;

  typedef struct packed {
    logic                 valid;
    logic [DB_XLEN-1:0]   pc;
    logic [31:0]          instr;
    logic                 exception;
    logic [DB_CWIDTH-1:0] ecause;
    logic [DB_XLEN-1:0]   etval;
    logic                 flush;
    logic                 out_ready;
  } decode_buffer_in_type;

  typedef struct packed {
    logic                    in_ready;
    logic                    valid;
    decode_buffer_entry_type head;
    logic [DB_CNTW-1:0]      count;
    logic                    almost_full;
  } decode_buffer_out_type;

  // Callers truncate the result to their own XLEN, which gives the modulo wrap
  function automatic logic [63:0] next_pc(input logic [63:0] pc, input logic [31:0] instr);
    return pc + ((instr[1:0] == ILEN_FULL) ? 64'd4 : 64'd2);
  endfunction

endpackage

// File: rtl/decode_buffer_if.sv
// rtl/decode_buffer_if.sv - fetch/decode handshake bundle for the decode buffer
interface decode_buffer_if #(
  parameter int XLEN   = decode_buffer_pkg::DB_XLEN,
  parameter int DEPTH  = decode_buffer_pkg::DB_DEPTH,
  parameter int CWIDTH = decode_buffer_pkg::DB_CWIDTH
);

  logic                       in_valid;
  logic                       in_ready;
  logic [XLEN-1:0]            in_pc;
  logic [31:0]                in_instr;
  logic                       in_exception;
  logic [CWIDTH-1:0]          in_ecause;
  logic [XLEN-1:0]            in_etval;
  logic                       flush;
  logic                       out_valid;
  logic                       out_ready;
  logic [XLEN-1:0]            out_pc;
  logic [XLEN-1:0]            out_npc;
  logic [31:0]                out_instr;
  logic                       out_exception;
  logic [CWIDTH-1:0]          out_ecause;
  logic [XLEN-1:0]            out_etval;
  logic [$clog2(DEPTH+1)-1:0] count;
  logic                       almost_full;

  modport master (
    output in_valid, in_pc, in_instr, in_exception, in_ecause, in_etval, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_npc, out_instr, out_exception, out_ecause,
           out_etval, count, almost_full
  );

  modport slave (
    input  in_valid, in_pc, in_instr, in_exception, in_ecause, in_etval, flush, out_ready,
    output in_ready, out_valid, out_pc, out_npc, out_instr, out_exception, out_ecause,
           out_etval, count, almost_full
  );

endinterface

// File: rtl/decode_buffer.sv
// rtl/decode_buffer.sv - DEPTH-entry instruction queue between fetch and decode, flushed on redirect
module decode_buffer
  import decode_buffer_pkg::*;
#(
  parameter int XLEN   = DB_XLEN,
  parameter int DEPTH  = DB_DEPTH,
  parameter int CWIDTH = DB_CWIDTH
) (
  input  logic          clk,
  input  logic          rst,
  decode_buffer_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C   = CW'(DEPTH - 1);

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   npc;
    logic [31:0]       instr;
    logic              exception;
    logic [CWIDTH-1:0] ecause;
    logic [XLEN-1:0]   etval;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        wr_entry;
  entry_t        head;
  logic [PW-1:0] wr_ptr, rd_ptr, wr_ptr_d, rd_ptr_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          push, pop;

  always_comb begin
    push = bus.in_valid && (cnt < FULL_C) && !bus.flush;
    pop  = bus.out_ready && (cnt != '0) && !bus.flush;

    wr_entry.pc        = bus.in_pc;
    wr_entry.npc       = XLEN'(next_pc(64'(bus.in_pc), bus.in_instr));
    wr_entry.instr     = bus.in_instr;
    wr_entry.exception = bus.in_exception;
    wr_entry.ecause    = bus.in_ecause;
    wr_entry.etval     = bus.in_etval;

    wr_ptr_d = wr_ptr;
    rd_ptr_d = rd_ptr;
    cnt_d    = cnt;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   cnt_d = cnt + CW'(1);
        2'b01:   cnt_d = cnt - CW'(1);
        default: cnt_d = cnt;
      endcase
    end
  end

  // Flush only rewinds pointers; stale entry data is harmless once count is 0
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      wr_ptr <= wr_ptr_d;
      rd_ptr <= rd_ptr_d;
      cnt    <= cnt_d;
      if (push) mem[wr_ptr] <= wr_entry;
    end
  end

  assign head              = mem[rd_ptr];
  assign bus.in_ready      = (cnt < FULL_C);
  assign bus.out_valid     = (cnt != '0);
  assign bus.count         = cnt;
  assign bus.almost_full   = (cnt >= AF_C);
  assign bus.out_pc        = head.pc;
  assign bus.out_npc       = head.npc;
  assign bus.out_instr     = head.instr;
  assign bus.out_exception = head.exception;
  assign bus.out_ecause    = head.ecause;
  assign bus.out_etval     = head.etval;

endmodule

// File: tb/tb_decode_buffer.sv
// tb/tb_decode_buffer.sv - randomized and directed bench for decode_buffer against a queue model
module tb_decode_buffer;

  localparam int XLEN   = 32;
  localparam int DEPTH  = 4;
  localparam int CWIDTH = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  decode_buffer_if #(.XLEN(XLEN), .DEPTH(DEPTH), .CWIDTH(CWIDTH)) bus ();

  decode_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .CWIDTH(CWIDTH)) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] npc;
    logic [31:0] instr;
    logic        exc;
    logic [3:0]  ec;
    logic [31:0] etval;
  } ent_t;

  ent_t q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic idle();
    bus.in_valid     = 1'b0;
    bus.in_pc        = '0;
    bus.in_instr     = '0;
    bus.in_exception = 1'b0;
    bus.in_ecause    = '0;
    bus.in_etval     = '0;
    bus.flush        = 1'b0;
    bus.out_ready    = 1'b0;
  endtask

  task automatic set_push(input logic [31:0] pc, input logic [31:0] instr,
                          input logic exc, input logic [3:0] ec, input logic [31:0] etval);
    bus.in_valid     = 1'b1;
    bus.in_pc        = pc;
    bus.in_instr     = instr;
    bus.in_exception = exc;
    bus.in_ecause    = ec;
    bus.in_etval     = etval;
  endtask

  // Advance the reference queue by the current inputs, then clock the DUT
  task automatic step();
    ent_t e;
    bit   do_push, do_pop;
    do_push = bus.in_valid && (q.size() < DEPTH) && !bus.flush;
    do_pop  = bus.out_ready && (q.size() > 0) && !bus.flush;
    e.pc    = bus.in_pc;
    e.npc   = bus.in_pc + ((bus.in_instr[1:0] == 2'b11) ? 32'd4 : 32'd2);
    e.instr = bus.in_instr;
    e.exc   = bus.in_exception;
    e.ec    = bus.in_ecause;
    e.etval = bus.in_etval;
    if (bus.flush) q.delete();
    else begin
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    q.delete();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    vectors++;
    if (bus.count !== 3'd0) begin miscompares++; $display("FAIL reset_count: got %0d want 0", bus.count); end
    vectors++;
    if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    vectors++;
    if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    vectors++;
    if (bus.almost_full !== 1'b0) begin miscompares++; $display("FAIL reset_almost_full: got %b want 0", bus.almost_full); end
    vectors++;
    if ({bus.out_pc, bus.out_npc, bus.out_instr, bus.out_exception, bus.out_ecause, bus.out_etval} !== '0) begin
      miscompares++;
      $display("FAIL reset_head: got pc=%h npc=%h instr=%h want all zero", bus.out_pc, bus.out_npc, bus.out_instr);
    end
  endtask

  task automatic test_first_push();
    set_push(32'h100, 32'h0000_0013, 1'b0, 4'd0, 32'd0);
    vectors++;
    if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL first_same_cycle_valid: got %b want 0", bus.out_valid); end
    step();
    idle();
    vectors++;
    if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL first_valid: got %b want 1", bus.out_valid); end
    vectors++;
    if (bus.out_pc !== 32'h100) begin miscompares++; $display("FAIL first_pc: got %h want 00000100", bus.out_pc); end
    vectors++;
    if (bus.out_npc !== 32'h104) begin miscompares++; $display("FAIL first_npc: got %h want 00000104", bus.out_npc); end
    vectors++;
    if (bus.count !== 3'd1) begin miscompares++; $display("FAIL first_count: got %0d want 1", bus.count); end
    bus.out_ready = 1'b1;
    step();
    idle();
  endtask

  task automatic test_npc_wrap();
    set_push(32'hFFFF_FFFE, 32'h0000_4501, 1'b0, 4'd0, 32'd0);
    step();
    idle();
    vectors++;
    if (bus.out_npc !== 32'h0) begin miscompares++; $display("FAIL npc_wrap_c: got %h want 00000000", bus.out_npc); end
    bus.out_ready = 1'b1;
    set_push(32'hFFFF_FFFC, 32'h0000_0013, 1'b0, 4'd0, 32'd0);
    step();
    idle();
    vectors++;
    if (bus.out_npc !== 32'h0) begin miscompares++; $display("FAIL npc_wrap_full: got %h want 00000000", bus.out_npc); end
    bus.out_ready = 1'b1;
    step();
    idle();
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 5; i++) begin
      set_push(32'(i * 4), 32'h0000_0013, 1'b0, 4'd0, 32'd0);
      vectors++;
      if (bus.in_ready !== (i < DEPTH)) begin miscompares++; $display("FAIL fill_in_ready[%0d]: got %b want %b", i, bus.in_ready, (i < DEPTH)); end
      vectors++;
      if (bus.almost_full !== (i >= DEPTH - 1)) begin miscompares++; $display("FAIL fill_almost_full[%0d]: got %b want %b", i, bus.almost_full, (i >= DEPTH - 1)); end
      step();
    end
    idle();
    vectors++;
    if (bus.count !== 3'd4) begin miscompares++; $display("FAIL fill_count: got %0d want 4", bus.count); end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'(i * 4)) begin
        miscompares++;
        $display("FAIL drain_pc[%0d]: got valid=%b pc=%h want valid=1 pc=%h", i, bus.out_valid, bus.out_pc, 32'(i * 4));
      end
      step();
    end
    vectors++;
    if (bus.count !== 3'd0) begin miscompares++; $display("FAIL drain_count: got %0d want 0", bus.count); end
    idle();
  endtask

  task automatic test_full_concurrent();
    logic [31:0] exp_pc [6];
    logic [31:0] next_fetch;
    int          idx;
    for (int i = 0; i < 6; i++) exp_pc[i] = 32'h40 + 32'(i * 4);
    for (int i = 0; i < 4; i++) begin
      set_push(32'h40 + 32'(i * 4), 32'h0000_0013, 1'b0, 4'd0, 32'd0);
      step();
    end
    next_fetch = 32'h50;
    idx = 0;
    for (int c = 0; c < 3; c++) begin
      set_push(next_fetch, 32'h0000_0013, 1'b0, 4'd0, 32'd0);
      bus.out_ready = 1'b1;
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== exp_pc[idx]) begin
        miscompares++;
        $display("FAIL full_pop[%0d]: got valid=%b pc=%h want pc=%h", c, bus.out_valid, bus.out_pc, exp_pc[idx]);
      end
      idx++;
      if (bus.in_ready) next_fetch = next_fetch + 32'd4;
      step();
    end
    vectors++;
    if (bus.count !== 3'd3) begin miscompares++; $display("FAIL full_resume_count: got %0d want 3", bus.count); end
    idle();
    bus.out_ready = 1'b1;
    for (int c = 0; c < 10 && bus.out_valid; c++) begin
      vectors++;
      if (idx >= 6 || bus.out_pc !== exp_pc[idx]) begin
        miscompares++;
        $display("FAIL full_tail[%0d]: got pc=%h want pc=%h", idx, bus.out_pc, (idx < 6) ? exp_pc[idx] : 32'hx);
      end
      idx++;
      step();
    end
    vectors++;
    if (idx !== 6 || bus.count !== 3'd0) begin
      miscompares++;
      $display("FAIL full_total: got popped=%0d count=%0d want popped=6 count=0", idx, bus.count);
    end
    idle();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      set_push(32'h60 + 32'(i * 4), 32'h0000_0013, 1'b0, 4'd0, 32'd0);
      step();
    end
    vectors++;
    if (bus.count !== 3'd3 || bus.almost_full !== 1'b1) begin
      miscompares++;
      $display("FAIL preflush: got count=%0d af=%b want count=3 af=1", bus.count, bus.almost_full);
    end
    set_push(32'h70, 32'h0000_0013, 1'b0, 4'd0, 32'd0);
    bus.out_ready = 1'b1;
    bus.flush     = 1'b1;
    step();
    idle();
    vectors++;
    if (bus.count !== 3'd0 || bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_clear: got count=%0d valid=%b want count=0 valid=0", bus.count, bus.out_valid);
    end
    set_push(32'h80, 32'h0000_0013, 1'b0, 4'd0, 32'd0);
    step();
    idle();
    vectors++;
    if (bus.out_pc !== 32'h80 || bus.count !== 3'd1) begin
      miscompares++;
      $display("FAIL flush_next_head: got pc=%h count=%0d want pc=00000080 count=1", bus.out_pc, bus.count);
    end
    bus.out_ready = 1'b1;
    step();
    idle();
  endtask

  task automatic test_exception();
    set_push(32'h300, 32'h0000_0073, 1'b1, 4'd1, 32'h200);
    step();
    idle();
    vectors++;
    if ({bus.out_exception, bus.out_ecause, bus.out_etval, bus.out_pc, bus.out_instr} !==
        {1'b1, 4'd1, 32'h200, 32'h300, 32'h0000_0073}) begin
      miscompares++;
      $display("FAIL exception_entry: got exc=%b cause=%0d etval=%h pc=%h want exc=1 cause=1 etval=00000200 pc=00000300",
               bus.out_exception, bus.out_ecause, bus.out_etval, bus.out_pc);
    end
    bus.out_ready = 1'b1;
    step();
    idle();
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 2; i++) begin
      set_push(32'h400 + 32'(i * 4), 32'h0000_0013, 1'b0, 4'd0, 32'd0);
      step();
    end
    set_push(32'h408, 32'h0000_0013, 1'b0, 4'd0, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.count !== 3'd0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL async_reset: got count=%0d valid=%b ready=%b want 0/0/1", bus.count, bus.out_valid, bus.in_ready);
    end
    q.delete();
    idle();
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    logic [132:0] got, want;
    for (int c = 0; c < 400; c++) begin
      set_push($urandom, $urandom, ($urandom_range(0, 7) == 0), 4'($urandom), $urandom);
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      bus.flush     = ($urandom_range(0, 19) == 0);
      vectors++;
      if (int'(bus.count) !== q.size()) begin miscompares++; $display("FAIL rand_count[%0d]: got %0d want %0d", c, bus.count, q.size()); end
      vectors++;
      if (bus.out_valid !== (q.size() != 0) || bus.in_ready !== (q.size() < DEPTH) || bus.almost_full !== (q.size() >= DEPTH - 1)) begin
        miscompares++;
        $display("FAIL rand_flags[%0d]: got valid=%b ready=%b af=%b for occupancy %0d", c, bus.out_valid, bus.in_ready, bus.almost_full, q.size());
      end
      if (q.size() != 0) begin
        got  = {bus.out_pc, bus.out_npc, bus.out_instr, bus.out_exception, bus.out_ecause, bus.out_etval};
        want = {q[0].pc, q[0].npc, q[0].instr, q[0].exc, q[0].ec, q[0].etval};
        vectors++;
        if (got !== want) begin miscompares++; $display("FAIL rand_head[%0d]: got %h want %h", c, got, want); end
      end
      step();
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_first_push();
    test_npc_wrap();
    test_fill_drain();
    test_full_concurrent();
    test_flush();
    test_exception();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
